// File: rtl/ad_align_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad_align_pkg                                                             |
// | Shared FSM encoding, counter sizing helper and default test pattern.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ad_align_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK  = 4'd0,
        ST_SET_TAP    = 4'd1,
        ST_SETTLE     = 4'd2,
        ST_CHECK      = 4'd3,
        ST_NEXT_TAP   = 4'd4,
        ST_CENTER     = 4'd5,
        ST_SLIP_CHECK = 4'd6,
        ST_SLIP       = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    localparam logic [15:0] c_def_pattern = 16'hA55A;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_eye_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad_eye_tracker                                                           |
// | Tracks the longest run of passing IDELAY taps and its centre tap.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ad_eye_tracker
    import ad_align_pkg::*;
#(
    parameter int TAP_W   = 5,
    parameter int MIN_EYE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             upd,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] center,
    output logic             eye_ok
);

    localparam int c_len_w = cnt_w(2 ** TAP_W);
    localparam logic [c_len_w-1:0] c_len_max = c_len_w'(2 ** TAP_W);

    logic [TAP_W-1:0]   r_run_start;
    logic [TAP_W-1:0]   r_best_start;
    logic [c_len_w-1:0] r_run_len;
    logic [c_len_w-1:0] r_best_len;
    logic [TAP_W-1:0]   w_run_start;
    logic [c_len_w-1:0] w_run_len;

    always_comb begin
        w_run_start = (r_run_len == '0) ? tap : r_run_start;
        w_run_len   = (r_run_len == c_len_max) ? r_run_len : r_run_len + c_len_w'(1);
    end

    // Taps arrive in ascending order, so a strict '>' keeps the lower-start run on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (clr) begin
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (upd) begin
            if (pass) begin
                r_run_start <= w_run_start;
                r_run_len   <= w_run_len;
                if (w_run_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_len   <= w_run_len;
                end
            end else begin
                r_run_len <= '0;
            end
        end
    end

    assign center = r_best_start + TAP_W'(r_best_len >> 1);
    assign eye_ok = (r_best_len >= c_len_w'(MIN_EYE));

endmodule
`default_nettype wire

// File: rtl/ad_align_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad_align_ctrl                                                            |
// | LVDS ADC link trainer: IDELAY eye sweep/centre, then per-channel bitslip.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ad_align_ctrl
    import ad_align_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                DATA_W     = 16,
    parameter int                TAP_W      = 5,
    parameter logic [DATA_W-1:0] PATTERN    = DATA_W'(c_def_pattern),
    parameter int                SETTLE_CYC = 16,
    parameter int                CHECK_CYC  = 64,
    parameter int                MIN_EYE    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ad_lock,
    input  logic                     train_start,
    input  logic                     tap_fixed_en,
    input  logic [TAP_W-1:0]         tap_fixed,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH*TAP_W-1:0]  tap_out,
    output logic [NUM_CH-1:0]        tap_ld,
    output logic [NUM_CH-1:0]        bitslip,
    output logic [NUM_CH*DATA_W-1:0] ch_data_out,
    output logic                     data_valid,
    output logic                     aligned,
    output logic [NUM_CH-1:0]        train_err
);

    localparam int c_cnt_w  = cnt_w((SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC);
    localparam int c_slip_w = cnt_w(DATA_W);
    localparam logic [TAP_W-1:0]    c_tap_max     = '1;
    localparam logic [c_cnt_w-1:0]  c_settle_last = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_check_last  = c_cnt_w'(CHECK_CYC - 1);
    localparam logic [c_slip_w-1:0] c_slip_max    = c_slip_w'(DATA_W);

    state_t                  r_state;
    logic                    r_slip_phase;
    logic [TAP_W-1:0]        r_tap;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [NUM_CH-1:0]       r_pass, r_match, r_frozen, r_err, r_tap_ld, r_bitslip;
    logic [NUM_CH*TAP_W-1:0] r_tap_out;
    logic [NUM_CH*DATA_W-1:0] r_first, r_data_out;
    logic [c_slip_w-1:0]     r_slip_cnt [NUM_CH];
    logic                    r_aligned, r_valid;

    logic [NUM_CH-1:0]       w_pass, w_match, w_eye_ok, w_need, w_slip_fail, w_err_next;
    logic [NUM_CH*TAP_W-1:0] w_center_taps;
    logic                    w_first_smp, w_last_smp, w_eye_clr, w_eye_upd;

    assign w_first_smp = (r_cnt == '0);
    assign w_last_smp  = (r_cnt == c_check_last);
    assign w_eye_clr   = (r_state == ST_WAIT_LOCK);
    assign w_eye_upd   = (r_state == ST_CHECK) & w_last_smp & ad_lock;
    assign w_err_next  = r_err | w_slip_fail;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [DATA_W-1:0] w_smp;
            logic [TAP_W-1:0]  w_center;
            logic              w_slip_max;

            assign w_smp      = ch_data[k*DATA_W +: DATA_W];
            assign w_pass[k]  = w_first_smp | (r_pass[k] & (w_smp == r_first[k*DATA_W +: DATA_W]));
            assign w_match[k] = (w_first_smp | r_match[k]) & (w_smp == PATTERN);
            assign w_slip_max = (r_slip_cnt[k] == c_slip_max);
            assign w_need[k]      = ~r_frozen[k] & ~w_match[k] & ~w_slip_max;
            assign w_slip_fail[k] = ~r_frozen[k] & ~w_match[k] & w_slip_max;
            assign w_center_taps[k*TAP_W +: TAP_W] = w_eye_ok[k] ? w_center : tap_fixed;

            ad_eye_tracker #(
                .TAP_W   (TAP_W),
                .MIN_EYE (MIN_EYE)
            ) u_eye (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (w_eye_clr),
                .upd    (w_eye_upd),
                .pass   (w_pass[k]),
                .tap    (r_tap),
                .center (w_center),
                .eye_ok (w_eye_ok[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_LOCK;
            r_slip_phase <= 1'b0;
            r_tap        <= '0;
            r_cnt        <= '0;
            r_pass       <= '0;
            r_match      <= '0;
            r_frozen     <= '0;
            r_err        <= '0;
            r_tap_ld     <= '0;
            r_bitslip    <= '0;
            r_tap_out    <= '0;
            r_first      <= '0;
            r_data_out   <= '0;
            r_aligned    <= 1'b0;
            r_valid      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_slip_cnt[k] <= '0;
        end else begin
            r_tap_ld   <= '0;
            r_bitslip  <= '0;
            r_data_out <= ch_data;
            r_valid    <= (r_state == ST_DONE) & r_aligned & ad_lock & ~train_start;
            if (!ad_lock) begin
                r_state   <= ST_WAIT_LOCK;
                r_aligned <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT_LOCK: begin
                        r_err        <= '0;
                        r_tap        <= '0;
                        r_cnt        <= '0;
                        r_slip_phase <= 1'b0;
                        r_tap_ld     <= '1;
                        if (tap_fixed_en) begin
                            r_tap_out <= {NUM_CH{tap_fixed}};
                            r_state   <= ST_CENTER;
                        end else begin
                            r_tap_out <= '0;
                            r_state   <= ST_SET_TAP;
                        end
                    end
                    ST_SET_TAP: begin
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_cnt == c_settle_last) begin
                            r_cnt   <= '0;
                            r_state <= r_slip_phase ? ST_SLIP_CHECK : ST_CHECK;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                    ST_CHECK: begin
                        r_pass <= w_pass;
                        if (w_first_smp) r_first <= ch_data;
                        if (w_last_smp) begin
                            r_cnt   <= '0;
                            r_state <= ST_NEXT_TAP;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                    ST_NEXT_TAP: begin
                        r_tap_ld <= '1;
                        if (r_tap == c_tap_max) begin
                            r_tap_out <= w_center_taps;
                            r_err     <= ~w_eye_ok;
                            r_state   <= ST_CENTER;
                        end else begin
                            r_tap     <= r_tap + TAP_W'(1);
                            r_tap_out <= {NUM_CH{r_tap + TAP_W'(1)}};
                            r_state   <= ST_SET_TAP;
                        end
                    end
                    ST_CENTER: begin
                        r_frozen     <= r_err;
                        r_slip_phase <= 1'b1;
                        r_cnt        <= '0;
                        for (int k = 0; k < NUM_CH; k++) r_slip_cnt[k] <= '0;
                        r_state      <= ST_SETTLE;
                    end
                    ST_SLIP_CHECK: begin
                        r_match <= w_match;
                        if (w_last_smp) begin
                            r_cnt    <= '0;
                            r_frozen <= r_frozen | ~w_need;
                            r_err    <= w_err_next;
                            if (w_need == '0) begin
                                r_aligned <= ~|w_err_next;
                                r_state   <= ST_DONE;
                            end else begin
                                r_bitslip <= w_need;
                                r_state   <= ST_SLIP;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                    ST_SLIP: begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (r_bitslip[k] && (r_slip_cnt[k] != c_slip_max))
                                r_slip_cnt[k] <= r_slip_cnt[k] + c_slip_w'(1);
                        end
                        r_state <= ST_SETTLE;
                    end
                    ST_DONE: begin
                        if (train_start) begin
                            r_aligned <= 1'b0;
                            r_state   <= ST_WAIT_LOCK;
                        end
                    end
                    default: r_state <= ST_WAIT_LOCK;
                endcase
            end
        end
    end

    assign tap_out     = r_tap_out;
    assign tap_ld      = r_tap_ld;
    assign bitslip     = r_bitslip;
    assign ch_data_out = r_data_out;
    assign data_valid  = r_valid;
    assign aligned     = r_aligned;
    assign train_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ad_align_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ad_align_ctrl                                                         |
// | Directed bench with an ADC/IDELAY/ISERDES channel model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ad_align_ctrl;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int TAP_W  = 5;
    localparam logic [15:0] PAT = 16'hA55A;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ad_lock = 1'b0;
    logic                     train_start = 1'b0;
    logic                     tap_fixed_en = 1'b0;
    logic [TAP_W-1:0]         tap_fixed = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH*TAP_W-1:0]  tap_out;
    logic [NUM_CH-1:0]        tap_ld;
    logic [NUM_CH-1:0]        bitslip;
    logic [NUM_CH*DATA_W-1:0] ch_data_out;
    logic                     data_valid;
    logic                     aligned;
    logic [NUM_CH-1:0]        train_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Channel model: eye window per channel, word rotation advanced by bitslip.
    int lo [NUM_CH];
    int hi [NUM_CH];
    int off_init [NUM_CH];
    int bs_base [NUM_CH];
    int ld_base [NUM_CH];
    int cur_tap [NUM_CH];
    int n_ld [NUM_CH];
    int n_bs [NUM_CH];
    int cyc = 0;
    int strobes;
    logic [TAP_W-1:0] v;

    always #5 clk = ~clk;

    ad_align_ctrl #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .TAP_W      (TAP_W),
        .PATTERN    (PAT),
        .SETTLE_CYC (16),
        .CHECK_CYC  (64),
        .MIN_EYE    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ad_lock      (ad_lock),
        .train_start  (train_start),
        .tap_fixed_en (tap_fixed_en),
        .tap_fixed    (tap_fixed),
        .ch_data      (ch_data),
        .tap_out      (tap_out),
        .tap_ld       (tap_ld),
        .bitslip      (bitslip),
        .ch_data_out  (ch_data_out),
        .data_valid   (data_valid),
        .aligned      (aligned),
        .train_err    (train_err)
    );

    function automatic logic [15:0] rotl(input logic [15:0] w, input int n);
        int m;
        m = ((n % 16) + 16) % 16;
        return (w << m) | (w >> (16 - m));
    endfunction

    function automatic logic [19:0] pack(input int t0, input int t1, input int t2, input int t3);
        return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (tap_ld[k]) begin
                cur_tap[k] <= int'(tap_out[k*TAP_W +: TAP_W]);
                n_ld[k]    <= n_ld[k] + 1;
            end
            if (bitslip[k]) n_bs[k] <= n_bs[k] + 1;
        end
    end

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_tap[k] >= lo[k] && cur_tap[k] <= hi[k])
                ch_data[k*DATA_W +: DATA_W] = rotl(PAT, off_init[k] + n_bs[k] - bs_base[k]);
            else
                ch_data[k*DATA_W +: DATA_W] = 16'(cyc * 37 + k * 1000 + 1);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_eye(input int k, input int l, input int h, input int o);
        lo[k]       = l;
        hi[k]       = h;
        off_init[k] = o;
        bs_base[k]  = n_bs[k];
    endtask

    task automatic snap_ld();
        for (int k = 0; k < NUM_CH; k++) ld_base[k] = n_ld[k];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        train_start = 1'b1;
        @(negedge clk);
        train_start = 1'b0;
    endtask

    task automatic wait_aligned(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (aligned) break;
        end
        check(tag, 64'(aligned), 64'd1);
    endtask

    task automatic wait_ld(input int budget, output logic [TAP_W-1:0] val);
        val = '1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tap_ld[0]) begin
                val = tap_out[TAP_W-1:0];
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tap_out", 64'(tap_out), 64'd0);
        check("rst_tap_ld", 64'(tap_ld), 64'd0);
        check("rst_bitslip", 64'(bitslip), 64'd0);
        check("rst_data_out", 64'(ch_data_out), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_aligned", 64'(aligned), 64'd0);
        check("rst_err", 64'(train_err), 64'd0);
        rst_n = 1'b1;

        // Eyes 5..20 / 8..15, ch2 three bit positions off
        set_eye(0, 5, 20, 0); set_eye(1, 8, 15, 0); set_eye(2, 8, 15, 13); set_eye(3, 8, 15, 0);
        snap_ld();
        @(negedge clk);
        ad_lock = 1'b1;
        wait_aligned("a_aligned", 6000);
        check("a_taps", 64'(tap_out), 64'(pack(13, 12, 12, 12)));
        check("a_err", 64'(train_err), 64'd0);
        check("a_slips_ch2", 64'(n_bs[2] - bs_base[2]), 64'd3);
        check("a_slips_other", 64'((n_bs[0] - bs_base[0]) + (n_bs[1] - bs_base[1]) + (n_bs[3] - bs_base[3])), 64'd0);
        check("a_ld_count", 64'(n_ld[0] - ld_base[0]), 64'd33);
        @(negedge clk);
        check("a_valid", 64'(data_valid), 64'd1);
        check("a_data", 64'(ch_data_out), {PAT, PAT, PAT, PAT});

        // Narrow ch1 eye falls back to tap_fixed and flags an error
        set_eye(0, 8, 15, 0); set_eye(1, 10, 12, 0); set_eye(2, 8, 15, 0); set_eye(3, 8, 15, 0);
        tap_fixed = 5'd7;
        pulse_start();
        check("b_start_aligned", 64'(aligned), 64'd0);
        repeat (3200) @(negedge clk);
        check("b_err", 64'(train_err), 64'b0010);
        check("b_taps", 64'(tap_out), 64'(pack(12, 7, 12, 12)));
        check("b_aligned", 64'(aligned), 64'd0);
        check("b_valid", 64'(data_valid), 64'd0);

        // Lock loss during CHECK at tap 9
        set_eye(0, 5, 20, 0); set_eye(1, 8, 15, 0); set_eye(2, 8, 15, 0); set_eye(3, 8, 15, 0);
        pulse_start();
        wait_ld(200, v);
        check("c_first_tap", 64'(v), 64'd0);
        repeat (9) wait_ld(200, v);
        check("c_tap9", 64'(v), 64'd9);
        repeat (30) @(negedge clk);
        ad_lock = 1'b0;
        @(negedge clk);
        check("c_valid_low", 64'(data_valid), 64'd0);
        check("c_aligned_low", 64'(aligned), 64'd0);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            if ((|tap_ld) || (|bitslip)) strobes++;
        end
        check("c_no_strobes", 64'(strobes), 64'd0);
        snap_ld();
        ad_lock = 1'b1;
        wait_ld(200, v);
        check("c_restart_tap", 64'(v), 64'd0);
        wait_aligned("c_aligned", 6000);
        check("c_taps", 64'(tap_out), 64'(pack(13, 12, 12, 12)));
        check("c_err", 64'(train_err), 64'd0);
        check("c_ld_count", 64'(n_ld[0] - ld_base[0]), 64'd33);
        @(negedge clk);
        check("c_valid", 64'(data_valid), 64'd1);

        // Lock loss in DONE
        ad_lock = 1'b0;
        @(negedge clk);
        check("d_valid", 64'(data_valid), 64'd0);
        check("d_aligned", 64'(aligned), 64'd0);

        // Fixed-tap bypass, ch3 needs two slips
        set_eye(0, 18, 28, 0); set_eye(1, 18, 28, 0); set_eye(2, 18, 28, 0); set_eye(3, 18, 28, 14);
        tap_fixed    = 5'd23;
        tap_fixed_en = 1'b1;
        snap_ld();
        @(negedge clk);
        ad_lock = 1'b1;
        wait_aligned("e_aligned", 6000);
        check("e_taps", 64'(tap_out), 64'(pack(23, 23, 23, 23)));
        check("e_ld_count", 64'((n_ld[0] - ld_base[0]) + (n_ld[1] - ld_base[1]) + (n_ld[2] - ld_base[2]) + (n_ld[3] - ld_base[3])), 64'd4);
        check("e_slips_ch3", 64'(n_bs[3] - bs_base[3]), 64'd2);
        check("e_slips_other", 64'((n_bs[0] - bs_base[0]) + (n_bs[1] - bs_base[1]) + (n_bs[2] - bs_base[2])), 64'd0);
        check("e_err", 64'(train_err), 64'd0);

        // train_start mid-sweep is ignored, in DONE it retrains
        tap_fixed_en = 1'b0;
        set_eye(0, 5, 20, 0); set_eye(1, 8, 15, 0); set_eye(2, 8, 15, 0); set_eye(3, 8, 15, 0);
        snap_ld();
        pulse_start();
        repeat (5) wait_ld(200, v);
        check("f_tap4", 64'(v), 64'd4);
        repeat (10) @(negedge clk);
        pulse_start();
        wait_ld(200, v);
        check("f_tap5", 64'(v), 64'd5);
        wait_aligned("f_aligned", 6000);
        check("f_taps", 64'(tap_out), 64'(pack(13, 12, 12, 12)));
        check("f_ld_count", 64'(n_ld[0] - ld_base[0]), 64'd33);
        @(negedge clk);
        check("f_valid", 64'(data_valid), 64'd1);
        snap_ld();
        pulse_start();
        check("f_done_aligned", 64'(aligned), 64'd0);
        check("f_done_valid", 64'(data_valid), 64'd0);
        wait_aligned("f_re_aligned", 6000);
        check("f_re_taps", 64'(tap_out), 64'(pack(13, 12, 12, 12)));
        check("f_re_ld_count", 64'(n_ld[0] - ld_base[0]), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
